// File: rtl/mem_access_unit_if.sv
// Bus request/response channel between the memory access unit and the memory
// system. The unit is the master; memory (or a bench model) is the slave.
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory access unit for the MEM pipeline stage. Turns a load/store request
// from the EX/MEM register into one word-aligned bus transaction, extracts and
// extends load data, and reports completion, fault and stall to the pipeline.
// Build option: MISALIGN_CHECK_EN -- when defined, misaligned half/word
// accesses fault immediately without a bus request; otherwise the low address
// bits are cleared to natural alignment.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       ALUResult_m,
    input  logic [31:0]       StoreData_m,
    input  logic              WE_m,
    input  logic              RE_m,
    input  logic [1:0]        Size_m,
    input  logic              Unsigned_m,
    mem_access_unit_if.master bus,
    output logic [31:0]       LoadData_m,
    output logic              mem_done,
    output logic              mem_fault,
    output logic              mem_stall
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [29:0] word_addr;
    logic [1:0]  lane_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [15:0] wait_cnt;
    logic [31:0] load_q;
    logic        fault_q;
    logic        access;
    logic        misalign;
    logic        timeout;
    logic [1:0]  lane_in;

    // Byte lane of the access after forcing natural alignment.
    function automatic logic [1:0] lane_of(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            2'b00:   return addr_lo;
            2'b01:   return {addr_lo[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] make_wstrb(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   return 4'b0001 << lane;
            2'b01:   return 4'b0011 << lane;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the source so the slave finds it in whichever lane the strobe selects.
    function automatic logic [31:0] make_wdata(input logic [1:0] size, input logic [31:0] data);
        case (size)
            2'b00:   return {4{data[7:0]}};
            2'b01:   return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [1:0] size,
                                                 input logic [1:0] lane, input logic uns);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] b_ext;
        logic signed [31:0] h_ext;
        b     = rdata[{lane, 3'b000} +: 8];
        h     = rdata[{lane, 3'b000} +: 16];
        b_ext = b;
        h_ext = h;
        case (size)
            2'b00:   return uns ? {24'h000000, b} : b_ext;
            2'b01:   return uns ? {16'h0000, h} : h_ext;
            default: return rdata;
        endcase
    endfunction

    assign access  = WE_m | RE_m;
    assign lane_in = lane_of(Size_m, ALUResult_m[1:0]);
    assign timeout = (wait_cnt == TIMEOUT_LAST);

`ifdef MISALIGN_CHECK_EN
    assign misalign = ((Size_m == 2'b01) && ALUResult_m[0]) ||
                      (Size_m[1] && (ALUResult_m[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake/status outputs; stall in IDLE is gated by reset
    // so a request held on the inputs cannot show through while reset is low.
    always_comb begin
        state_next    = state;
        bus.req_valid = 1'b0;
        mem_done      = 1'b0;
        mem_stall     = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    mem_stall  = reset_n;
                    state_next = misalign ? DONE : REQ;
                end
            end
            REQ: begin
                bus.req_valid = 1'b1;
                mem_stall     = 1'b1;
                if (bus.req_ready) state_next = WAIT;
            end
            WAIT: begin
                mem_stall = 1'b1;
                if (bus.rsp_valid || timeout) state_next = DONE;
            end
            DONE: begin
                mem_done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Capture the access in IDLE, time the response in WAIT, and register the
    // result on the way into DONE; response priority over timeout on the last cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_addr <= '0;
            lane_q    <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wait_cnt  <= '0;
            load_q    <= '0;
            fault_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        if (misalign) begin
                            load_q  <= '0;
                            fault_q <= 1'b1;
                        end else begin
                            word_addr <= ALUResult_m[31:2];
                            lane_q    <= lane_in;
                            size_q    <= Size_m;
                            uns_q     <= Unsigned_m;
                            we_q      <= WE_m;
                            wdata_q   <= make_wdata(Size_m, StoreData_m);
                            wstrb_q   <= make_wstrb(Size_m, lane_in);
                        end
                    end
                end
                REQ: begin
                    wait_cnt <= '0;
                end
                WAIT: begin
                    if (bus.rsp_valid) begin
                        load_q  <= we_q ? 32'h0 : load_extract(bus.rsp_rdata, size_q, lane_q, uns_q);
                        fault_q <= bus.rsp_err;
                    end else if (timeout) begin
                        load_q  <= '0;
                        fault_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_we    = we_q;
    assign bus.req_addr  = {word_addr, 2'b00};
    assign bus.req_wdata = wdata_q;
    assign bus.req_wstrb = wstrb_q;
    assign LoadData_m    = load_q;
    assign mem_fault     = fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios followed by randomized
// accesses, each checked against a behavioural model of the access rules.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] ALUResult_m;
    logic [31:0] StoreData_m;
    logic        WE_m;
    logic        RE_m;
    logic [1:0]  Size_m;
    logic        Unsigned_m;
    logic [31:0] LoadData_m;
    logic        mem_done;
    logic        mem_fault;
    logic        mem_stall;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] prev_load = 32'h0;
    logic        prev_fault = 1'b0;

    mem_access_unit_if bus_if ();

    mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ALUResult_m (ALUResult_m),
        .StoreData_m (StoreData_m),
        .WE_m        (WE_m),
        .RE_m        (RE_m),
        .Size_m      (Size_m),
        .Unsigned_m  (Unsigned_m),
        .bus         (bus_if),
        .LoadData_m  (LoadData_m),
        .mem_done    (mem_done),
        .mem_fault   (mem_fault),
        .mem_stall   (mem_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int nbytes(input logic [1:0] s);
        if (s == 2'b00) return 1;
        if (s == 2'b01) return 2;
        return 4;
    endfunction

    function automatic int lane_model(input logic [31:0] a, input int nb);
        int lo;
        lo = int'(a[1:0]);
        return (lo / nb) * nb;
    endfunction

    function automatic logic mis_model(input logic [31:0] a, input int nb);
`ifdef MISALIGN_CHECK_EN
        return (int'(a[1:0]) % nb) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [3:0] exp_wstrb(input int lane, input int nb);
        logic [3:0] w;
        w = 4'b0000;
        for (int i = 0; i < nb; i++) w[lane + i] = 1'b1;
        return w;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [31:0] d, input int nb);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % nb) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] rd, input int lane, input int nb,
                                             input logic uns);
        longint v;
        longint span;
        v = longint'(rd) >> (8 * lane);
        if (nb < 4) begin
            span = longint'(1) << (8 * nb);
            v = v % span;
            if (!uns && v >= span / 2) v = v - span;
        end
        return 32'(v);
    endfunction

    // One complete access from the IDLE cycle through DONE and one idle cycle
    // with a stray response. rsp_delay = 0 means the slave never responds.
    task automatic run_access(input logic [31:0] addr, input logic [31:0] data, input logic we,
                              input logic re, input logic [1:0] size, input logic uns,
                              input int ready_delay, input int rsp_delay,
                              input logic [31:0] rdata, input logic err);
        int          nb, lane, k, valid_cycles, wait_cycles, exp_k;
        logic        mis, finished, exp_fault;
        logic [31:0] exp_ld;
        nb   = nbytes(size);
        lane = lane_model(addr, nb);
        mis  = mis_model(addr, nb);
        exp_k     = mis ? 2 : 1 + (ready_delay + 1) + ((rsp_delay == 0) ? TO : rsp_delay) + 1;
        exp_fault = mis ? 1'b1 : ((rsp_delay == 0) ? 1'b1 : err);
        exp_ld    = (mis || rsp_delay == 0 || we) ? 32'h0 : exp_load(rdata, lane, nb, uns);

        ALUResult_m = addr;
        StoreData_m = data;
        WE_m = we;
        RE_m = re;
        Size_m = size;
        Unsigned_m = uns;
        bus_if.req_ready = 1'b0;
        bus_if.rsp_valid = 1'b0;
        #1;
        check("idle_stall", 32'(mem_stall), 32'h1);
        check("idle_valid", 32'(bus_if.req_valid), 32'h0);
        check("idle_hold_load", LoadData_m, prev_load);

        k = 1;
        valid_cycles = 0;
        wait_cycles = 0;
        finished = 1'b0;
        while (!finished && k < 100) begin
            @(posedge clk);
            #1;
            k++;
            bus_if.req_ready = 1'b0;
            bus_if.rsp_valid = 1'b0;
            bus_if.rsp_rdata = $urandom;
            bus_if.rsp_err   = 1'($urandom);
            if (mem_done) begin
                finished = 1'b1;
            end else if (bus_if.req_valid) begin
                valid_cycles++;
                check("req_addr", bus_if.req_addr, addr & 32'hFFFF_FFFC);
                check("req_we", 32'(bus_if.req_we), 32'(we));
                check("req_wstrb", 32'(bus_if.req_wstrb), 32'(exp_wstrb(lane, nb)));
                check("req_wdata", bus_if.req_wdata, exp_wdata(data, nb));
                check("req_stall", 32'(mem_stall), 32'h1);
                check("req_hold_fault", 32'(mem_fault), 32'(prev_fault));
                bus_if.req_ready = (valid_cycles > ready_delay);
                bus_if.rsp_valid = 1'($urandom);
            end else begin
                wait_cycles++;
                check("wait_stall", 32'(mem_stall), 32'h1);
                check("wait_hold_load", LoadData_m, prev_load);
                if (rsp_delay != 0 && wait_cycles == rsp_delay) begin
                    bus_if.rsp_valid = 1'b1;
                    bus_if.rsp_rdata = rdata;
                    bus_if.rsp_err   = err;
                end
            end
        end
        check("done_reached", 32'(finished), 32'h1);
        if (!finished) return;

        check("latency", 32'(k), 32'(exp_k));
        check("valid_cycles", 32'(valid_cycles), mis ? 32'h0 : 32'(ready_delay + 1));
        check("done_load", LoadData_m, exp_ld);
        check("done_fault", 32'(mem_fault), 32'(exp_fault));
        check("done_stall", 32'(mem_stall), 32'h0);
        check("done_valid", 32'(bus_if.req_valid), 32'h0);

        // Request inputs still held during DONE must not start a new access.
        @(posedge clk);
        #1;
        check("after_done", 32'(mem_done), 32'h0);
        WE_m = 1'b0;
        RE_m = 1'b0;
        bus_if.rsp_valid = 1'b1;
        bus_if.rsp_rdata = $urandom;
        bus_if.rsp_err   = 1'b1;
        #1;
        check("idle_no_stall", 32'(mem_stall), 32'h0);
        @(posedge clk);
        #1;
        bus_if.rsp_valid = 1'b0;
        bus_if.rsp_err   = 1'b0;
        check("stray_load", LoadData_m, exp_ld);
        check("stray_fault", 32'(mem_fault), 32'(exp_fault));
        check("stray_done", 32'(mem_done), 32'h0);
        prev_load  = exp_ld;
        prev_fault = exp_fault;
    endtask

    initial begin
        reset_n = 1'b1;
        ALUResult_m = 32'h0;
        StoreData_m = 32'h0;
        WE_m = 1'b0;
        RE_m = 1'b0;
        Size_m = 2'b10;
        Unsigned_m = 1'b0;
        bus_if.req_ready = 1'b0;
        bus_if.rsp_valid = 1'b0;
        bus_if.rsp_rdata = 32'h0;
        bus_if.rsp_err   = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("rst_valid", 32'(bus_if.req_valid), 32'h0);
        check("rst_stall", 32'(mem_stall), 32'h0);
        check("rst_done", 32'(mem_done), 32'h0);
        check("rst_fault", 32'(mem_fault), 32'h0);
        check("rst_load", LoadData_m, 32'h0);
        check("rst_addr", bus_if.req_addr, 32'h0);
        check("rst_wstrb", 32'(bus_if.req_wstrb), 32'h0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Word load, minimum latency
        run_access(32'h0000_1000, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0, 0, 1, 32'hDEAD_BEEF, 1'b0);
        // Signed and unsigned byte loads from the top lane
        run_access(32'h0000_1003, 32'h0, 1'b0, 1'b1, 2'b00, 1'b0, 0, 1, 32'h8011_2233, 1'b0);
        run_access(32'h0000_1003, 32'h0, 1'b0, 1'b1, 2'b00, 1'b1, 0, 1, 32'h8011_2233, 1'b0);
        // Half store with a slow slave
        run_access(32'h0000_2002, 32'h0000_ABCD, 1'b1, 1'b0, 2'b01, 1'b0, 3, 1, 32'h0, 1'b0);
        // Load and store both requested: treated as a store
        run_access(32'h0000_2001, 32'h1234_5678, 1'b1, 1'b1, 2'b00, 1'b0, 0, 2, 32'hFFFF_FFFF, 1'b0);
        // Timeout with no response, then a stray response in IDLE
        run_access(32'h0000_3000, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0, 0, 0, 32'h0, 1'b0);
        // Misaligned word load
        run_access(32'h0000_1001, 32'h0, 1'b0, 1'b1, 2'b10, 1'b0, 0, 1, 32'hCAFE_F00D, 1'b0);
        // Size 11 behaves as word; bus error reported
        run_access(32'h0000_4004, 32'h0, 1'b0, 1'b1, 2'b11, 1'b0, 1, 2, 32'h5A5A_1234, 1'b1);

        // Reset during WAIT
        ALUResult_m = 32'h0000_5000;
        Size_m = 2'b10;
        WE_m = 1'b0;
        RE_m = 1'b1;
        @(posedge clk);
        #1 bus_if.req_ready = 1'b1;
        @(posedge clk);
        #1 bus_if.req_ready = 1'b0;
        check("wait_before_rst", 32'(mem_stall), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_valid", 32'(bus_if.req_valid), 32'h0);
        check("midrst_stall", 32'(mem_stall), 32'h0);
        check("midrst_load", LoadData_m, 32'h0);
        check("midrst_fault", 32'(mem_fault), 32'h0);
        check("midrst_wdata", bus_if.req_wdata, 32'h0);
        RE_m = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        bus_if.rsp_valid = 1'b1;
        bus_if.rsp_rdata = 32'h7777_7777;
        bus_if.rsp_err   = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("postrst_done", 32'(mem_done), 32'h0);
            check("postrst_stall", 32'(mem_stall), 32'h0);
            check("postrst_load", LoadData_m, 32'h0);
            check("postrst_fault", 32'(mem_fault), 32'h0);
        end
        bus_if.rsp_valid = 1'b0;
        bus_if.rsp_err   = 1'b0;
        prev_load  = 32'h0;
        prev_fault = 1'b0;

        // Randomized accesses
        for (int n = 0; n < 40; n++) begin
            logic we_r;
            we_r = 1'($urandom);
            run_access($urandom, $urandom, we_r, we_r ? 1'($urandom) : 1'b1, 2'($urandom),
                       1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, TO)),
                       $urandom, ($urandom_range(0, 7) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the max WAIT cycles before a bus-timeout fault (range 1..65535).
REQ-002 clk  in  1  SHALL be the sole clock, rising edge.
REQ-003 reset_n  in  1  SHALL be the reset: asynchronous, active-low.
REQ-004 ALUResult_m  in  32  SHALL be the byte address from the EX/MEM register.
REQ-005 StoreData_m  in  32  SHALL be the store data from the EX/MEM register.
REQ-006 WE_m  in  1  SHALL be the store request; RE_m  in  1  SHALL be the load request.
REQ-007 Size_m  in  2  SHALL be 00 byte, 01 half, 10 word; 11 SHALL be treated as word.
REQ-008 Unsigned_m  in  1  SHALL select zero-extension (1) or sign-extension (0) for loads.
REQ-009 req_valid out 1, req_ready in 1, req_we out 1, req_addr out 32 (bits [1:0]=0), req_wdata out 32, req_wstrb out 4 SHALL form the bus request channel.
REQ-010 rsp_valid in 1, rsp_rdata in 32, rsp_err in 1 SHALL form the bus response channel.
REQ-011 LoadData_m out 32, mem_done out 1, mem_fault out 1, mem_stall out 1 SHALL be the pipeline-side results.

Function
REQ-012 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-013 IDLE with WE_m|RE_m SHALL drive mem_stall=1 combinationally and go to REQ next edge, latching address, data, size, unsigned, and direction.
REQ-014 WE_m and RE_m both high SHALL be treated as a store.
REQ-015 REQ SHALL hold req_valid=1 and all req_* stable until the req_ready edge, then go to WAIT.
REQ-016 WAIT SHALL go to DONE on rsp_valid, registering the extracted load data and fault=rsp_err.
REQ-017 WAIT SHALL count cycles and, after TIMEOUT_CYCLES cycles without rsp_valid, go to DONE with fault=1 and LoadData_m=0.
REQ-018 rsp_valid outside WAIT SHALL be ignored.
REQ-019 DONE SHALL last exactly one cycle with mem_done=1, mem_stall=0, mem_fault valid, then return to IDLE without re-sampling inputs that cycle.
REQ-020 mem_stall SHALL be 1 in REQ and WAIT, and in IDLE only when an access is pending.
REQ-021 Minimum access latency SHALL be 4 cycles, IDLE to DONE inclusive, with req_ready=1 and rsp_valid one cycle after acceptance.
REQ-022 req_wstrb SHALL be: byte 0001<<addr[1:0]; half 0011<<{addr[1],0}; word 1111.
REQ-023 req_wdata SHALL replicate the source: byte {4{data[7:0]}}, half {2{data[15:0]}}, word data.
REQ-024 Loads SHALL select the byte/half lane by addr[1:0] and extend per Unsigned_m; store completion SHALL give LoadData_m=0.
REQ-025 LoadData_m and mem_fault SHALL hold their value until the next DONE.

Reset
REQ-026 reset_n low SHALL force, immediately and including mid-transaction: state IDLE; req_valid, req_we, mem_done, mem_fault, mem_stall = 0; req_addr, req_wdata, LoadData_m, timeout counter = 0; req_wstrb = 0000.
REQ-027 A bus response arriving after reset release for an aborted transaction SHALL be ignored.

Configuration
REQ-028 With MISALIGN_CHECK_EN defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL issue no bus request and SHALL go IDLE->DONE with mem_fault=1 and LoadData_m=0 (stall 1 cycle).
REQ-029 Without MISALIGN_CHECK_EN, misaligned low address bits SHALL be cleared to natural alignment, and no misalignment fault SHALL exist.

Verification
REQ-030 Word load, addr 0x1000, req_ready=1, rsp_rdata=0xDEADBEEF after 1 cycle -> req_addr=0x1000, wstrb=1111, DONE on cycle 4, LoadData_m=0xDEADBEEF, mem_fault=0.
REQ-031 Signed byte load, addr 0x1003, rdata=0x80112233 -> LoadData_m=0xFFFFFF80; with Unsigned_m=1 -> 0x00000080.
REQ-032 Half store, addr 0x2002, data 0x0000ABCD, req_ready low 3 cycles -> req_valid held 4 cycles, wstrb=1100, wdata=0xABCDABCD, stall held until DONE.
REQ-033 Load with no rsp_valid, TIMEOUT_CYCLES=4 -> DONE after 4 WAIT cycles, mem_fault=1, LoadData_m=0; a later stray rsp_valid is ignored.
REQ-034 reset_n low during WAIT -> req_valid and mem_stall 0 immediately, state IDLE; a response after release is ignored.
REQ-035 Word load at 0x1001: with MISALIGN_CHECK_EN -> no req_valid, mem_fault=1 on the next cycle; without it -> req_addr=0x1000, fault=0.
